// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the x72 instruction sequencer: FSM state encoding
// and the default geometry used by the sequencer and its FIFO.
package x72_seq_pkg;

  localparam int DEF_WIDTH   = 9;   // matches the processor's Din width
  localparam int DEF_DEPTH   = 16;  // FIFO entries, power of two
  localparam int DEF_TIMEOUT = 64;  // WAIT cycles allowed before abort

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_fifo.sv
// Synchronous FIFO holding instruction words for the sequencer.
// Pointers carry an extra wrap bit so full and empty are distinguishable
// with equal low bits. Both flags are registered from the next-state
// pointers, so they reflect the edge that caused the change. The head word
// is read combinationally so a word pushed at edge E can be popped and
// latched by the parent at E+1 without a prefetch bubble.
module sync_fifo
  import x72_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW:0]      rd_ptr_reg, rd_ptr_next;
  logic             full_reg, full_next;
  logic             empty_reg, empty_next;
  logic             push_ok, pop_ok;

  // A push into a full FIFO is dropped here; the parent flags it.
  assign push_ok = push && !full_reg;
  assign pop_ok  = pop && !empty_reg;

  // Next pointers and the flags they imply.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
    rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
    empty_next  = (wr_ptr_next == rd_ptr_next);
    full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                  (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
  end

  // Pointer and flag registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
    end
  end

  // Storage write; contents need no reset since the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];
  assign full     = full_reg;
  assign empty    = empty_reg;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host-loaded instruction words and issues
// them one at a time to the x72 processor over the run/done handshake.
// A run pulse accompanies each issued word; the next word goes out on the
// edge that accepts done (no bubble). A missing done aborts after TIMEOUT
// WAIT cycles with the FIFO left intact.
module instr_sequencer
  import x72_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  input  logic             start,
  output logic [WIDTH-1:0] din,
  output logic             run,
  input  logic             done,
  output logic             busy,
  output logic             all_done,
  output logic             overflow,
  output logic             timeout_err,
  output logic [15:0]      exec_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The abort edge is the one on which the counter would reach TIMEOUT.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  seq_state_t       state_reg;
  logic [WIDTH-1:0] din_reg;
  logic             run_reg;
  logic             busy_reg;
  logic             all_done_reg;
  logic             overflow_reg;
  logic             timeout_reg;
  logic [15:0]      exec_count_reg;
  logic [CW-1:0]    wait_cnt_reg;

  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             valid_done;
  logic             fifo_pop;

  // done on the cycle run is still high belongs to the previous handshake
  // and is not accepted.
  assign valid_done = (state_reg == WAIT) && done && !run_reg;

  // Pop on a start from IDLE or on an accepted done; the FIFO itself
  // ignores the request when it is empty.
  assign fifo_pop = ((state_reg == IDLE) && start) || valid_done;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer FSM with wait counter, completion count and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      din_reg        <= '0;
      run_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      all_done_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
      timeout_reg    <= 1'b0;
      exec_count_reg <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      run_reg      <= 1'b0;
      all_done_reg <= 1'b0;

      if (wr_en && fifo_full) begin
        overflow_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start && !fifo_empty) begin
            din_reg      <= fifo_head;
            run_reg      <= 1'b1;
            wait_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= WAIT;
          end
        end

        WAIT: begin
          if (valid_done) begin
            exec_count_reg <= exec_count_reg + 16'd1;
            if (!fifo_empty) begin
              din_reg      <= fifo_head;
              run_reg      <= 1'b1;
              wait_cnt_reg <= '0;
            end else begin
              all_done_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= IDLE;
            end
          end else if (wait_cnt_reg == LAST_WAIT) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign din         = din_reg;
  assign run         = run_reg;
  assign busy        = busy_reg;
  assign all_done    = all_done_reg;
  assign overflow    = overflow_reg;
  assign timeout_err = timeout_reg;
  assign exec_count  = exec_count_reg;
  assign full        = fifo_full;
  assign empty       = fifo_empty;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Accepted host words are pushed
// onto an expected-word queue; each word the DUT issues with run is popped
// from it and compared.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [8:0]  wr_data;
  logic        full;
  logic        empty;
  logic        start;
  logic [8:0]  din;
  logic        run;
  logic        done;
  logic        busy;
  logic        all_done;
  logic        overflow;
  logic        timeout_err;
  logic [15:0] exec_count;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .start       (start),
    .din         (din),
    .run         (run),
    .done        (done),
    .busy        (busy),
    .all_done    (all_done),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .exec_count  (exec_count)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs set afterwards are sampled next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; done = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic host_write(input logic [8:0] w, input bit accept);
    wr_en = 1'b1;
    wr_data = w;
    if (accept) exp_q.push_back(w);
    tick();
    wr_en = 1'b0;
    $display("  write 0x%03h full=%0b overflow=%0b", w, full, overflow);
  endtask

  // Optionally pulse start, then answer each run with done lat edges later
  // until all_done or the cycle budget runs out. Issued words go to obs_q.
  task automatic serve(input bit do_start, input int lat, input int budget,
                       output int n_all);
    int k;
    bit pending;
    bit fin;
    k = 0; pending = 0; fin = 0; n_all = 0;
    obs_q.delete();
    if (do_start) start = 1'b1;
    for (int c = 0; c < budget && !fin; c++) begin
      tick();
      start = 1'b0;
      if (run === 1'b1) begin
        obs_q.push_back(din);
        $display("  issue %0d din=0x%03h exec_count=%0d", obs_q.size(), din, exec_count);
        k = 0;
        pending = 1;
      end else begin
        k++;
      end
      if (all_done === 1'b1) begin
        n_all++;
        fin = 1;
      end
      done = pending && (k == lat - 1);
      if (done) pending = 0;
    end
    done = 1'b0;
  endtask

  // Check that every output is at its reset value.
  task automatic test_reset();
    logic [15:0] got [9];
    logic [15:0] want[9];
    string       nm  [9];
    do_reset();
    nm   = '{"din", "run", "busy", "all_done", "overflow", "timeout_err",
             "exec_count", "empty", "full"};
    got  = '{16'(din), 16'(run), 16'(busy), 16'(all_done), 16'(overflow),
             16'(timeout_err), exec_count, 16'(empty), 16'(full)};
    want = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0};
    for (int i = 0; i < 9; i++) begin
      compared++;
      if (got[i] !== want[i]) begin
        mismatched++;
        $display("FAIL reset_%s: got 0x%0h want 0x%0h", nm[i], got[i], want[i]);
      end
    end
    $display("  reset checked");
  endtask

  // Three words, done four cycles after each run.
  task automatic test_basic_sequence();
    int n_all;
    logic [8:0] e;
    do_reset();
    host_write(9'h1A5, 1); host_write(9'h003, 1); host_write(9'h0FF, 1);
    serve(1, 4, 200, n_all);
    compared++;
    if (obs_q.size() != 3) begin
      mismatched++; $display("FAIL basic_issue_count: got %0d want 3", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q[0] !== e) begin
        mismatched++; $display("FAIL basic_din: got 0x%03h want 0x%03h", obs_q[0], e);
      end
      void'(obs_q.pop_front());
    end
    compared++;
    if (n_all != 1) begin mismatched++; $display("FAIL basic_all_done_count: got %0d want 1", n_all); end
    compared++;
    if (exec_count !== 16'd3) begin mismatched++; $display("FAIL basic_exec_count: got %0d want 3", exec_count); end
    compared++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL basic_idle_empty: got empty=%0b busy=%0b want 1/0", empty, busy);
    end
    tick();
    compared++;
    if (all_done !== 1'b0) begin mismatched++; $display("FAIL basic_all_done_pulse: got %0b want 0", all_done); end
  endtask

  // Seventeen writes into a 16-deep FIFO, then drain.
  task automatic test_overflow();
    int n_all;
    logic [8:0] e;
    logic [8:0] w;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      w = 9'(i * 29 + 7);
      host_write(w, 1);
    end
    compared++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      mismatched++; $display("FAIL ovf_full16: got full=%0b overflow=%0b want 1/0", full, overflow);
    end
    host_write(9'h155, 0);
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    serve(1, 2, 400, n_all);
    compared++;
    if (obs_q.size() != 16) begin
      mismatched++; $display("FAIL ovf_issue_count: got %0d want 16", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q[0] !== e) begin
        mismatched++; $display("FAIL ovf_din: got 0x%03h want 0x%03h", obs_q[0], e);
      end
      void'(obs_q.pop_front());
    end
    compared++;
    if (exec_count !== 16'd16 || overflow !== 1'b1) begin
      mismatched++; $display("FAIL ovf_end: got exec_count=%0d overflow=%0b want 16/1", exec_count, overflow);
    end
  endtask

  // One word issued and never answered: abort exactly 64 cycles after issue.
  task automatic test_timeout();
    int n_all;
    logic [8:0] e;
    do_reset();
    host_write(9'h011, 1); host_write(9'h022, 1); host_write(9'h033, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    compared++;
    if (run !== 1'b1 || din !== e) begin
      mismatched++; $display("FAIL to_issue: got run=%0b din=0x%03h want 1/0x%03h", run, din, e);
    end
    for (int i = 0; i < 63; i++) tick();
    compared++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      mismatched++; $display("FAIL to_early: got busy=%0b timeout_err=%0b want 1/0 at 63", busy, timeout_err);
    end
    tick();
    compared++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      mismatched++; $display("FAIL to_fire: got busy=%0b timeout_err=%0b want 0/1 at 64", busy, timeout_err);
    end
    compared++;
    if (exec_count !== 16'd0 || empty !== 1'b0) begin
      mismatched++; $display("FAIL to_state: got exec_count=%0d empty=%0b want 0/0", exec_count, empty);
    end
    serve(1, 3, 100, n_all);
    compared++;
    if (obs_q.size() != 2) begin
      mismatched++; $display("FAIL to_remaining: got %0d want 2", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q[0] !== e) begin
        mismatched++; $display("FAIL to_din: got 0x%03h want 0x%03h", obs_q[0], e);
      end
      void'(obs_q.pop_front());
    end
    compared++;
    if (timeout_err !== 1'b1) begin mismatched++; $display("FAIL to_sticky: got %0b want 1", timeout_err); end
  endtask

  // done during the run-high cycle is ignored; next word issues with no bubble.
  task automatic test_back_to_back();
    do_reset();
    host_write(9'h0A0, 1); host_write(9'h0B1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (run !== 1'b1 || din !== exp_q[0]) begin
      mismatched++; $display("FAIL b2b_issue1: got run=%0b din=0x%03h want 1/0x%03h", run, din, exp_q[0]);
    end
    void'(exp_q.pop_front());
    done = 1'b1;
    tick();
    compared++;
    if (run !== 1'b0 || busy !== 1'b1 || exec_count !== 16'd0) begin
      mismatched++; $display("FAIL b2b_ignore: got run=%0b busy=%0b exec_count=%0d want 0/1/0", run, busy, exec_count);
    end
    tick();
    done = 1'b0;
    compared++;
    if (run !== 1'b1 || din !== exp_q[0] || exec_count !== 16'd1) begin
      mismatched++; $display("FAIL b2b_issue2: got run=%0b din=0x%03h exec_count=%0d want 1/0x%03h/1",
                             run, din, exec_count, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    compared++;
    if (all_done !== 1'b1 || busy !== 1'b0 || exec_count !== 16'd2) begin
      mismatched++; $display("FAIL b2b_finish: got all_done=%0b busy=%0b exec_count=%0d want 1/0/2",
                             all_done, busy, exec_count);
    end
  endtask

  // Reset in WAIT with words queued clears everything, including the FIFO.
  task automatic test_reset_mid_wait();
    logic [15:0] got [9];
    logic [15:0] want[9];
    string       nm  [9];
    do_reset();
    host_write(9'h101, 1); host_write(9'h102, 1); host_write(9'h103, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1; done = 1'b1;
    tick();
    rst = 1'b0; done = 1'b0;
    exp_q.delete();
    nm   = '{"din", "run", "busy", "all_done", "overflow", "timeout_err",
             "exec_count", "empty", "full"};
    got  = '{16'(din), 16'(run), 16'(busy), 16'(all_done), 16'(overflow),
             16'(timeout_err), exec_count, 16'(empty), 16'(full)};
    want = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0};
    for (int i = 0; i < 9; i++) begin
      compared++;
      if (got[i] !== want[i]) begin
        mismatched++;
        $display("FAIL rstwait_%s: got 0x%0h want 0x%0h", nm[i], got[i], want[i]);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (run !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL rstwait_start_ignored: got run=%0b busy=%0b want 0/0", run, busy);
    end
  endtask

  // A push on the same edge as the last done is not seen by that done.
  task automatic test_push_with_done();
    do_reset();
    host_write(9'h1C3, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    void'(exp_q.pop_front());
    tick();
    done = 1'b1; wr_en = 1'b1; wr_data = 9'h0E7;
    exp_q.push_back(9'h0E7);
    tick();
    done = 1'b0; wr_en = 1'b0;
    compared++;
    if (all_done !== 1'b1 || busy !== 1'b0 || exec_count !== 16'd1 || empty !== 1'b0) begin
      mismatched++; $display("FAIL pushdone_end: got all_done=%0b busy=%0b exec_count=%0d empty=%0b want 1/0/1/0",
                             all_done, busy, exec_count, empty);
    end
    tick();
    compared++;
    if (all_done !== 1'b0 || run !== 1'b0) begin
      mismatched++; $display("FAIL pushdone_idle: got all_done=%0b run=%0b want 0/0", all_done, run);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    compared++;
    if (run !== 1'b1 || din !== exp_q[0]) begin
      mismatched++; $display("FAIL pushdone_restart: got run=%0b din=0x%03h want 1/0x%03h", run, din, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    test_push_with_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute bound on run time in case the DUT stalls the bench.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
